// File: rtl/instruction_fetch_queue.sv
// Fetch front end: reads 2-word instructions from blockram into an in-order queue for decode.
// Latency: start -> header PC load -> first entry visible 3 cycles after the start pulse; 1 instr/cycle.
// Backpressure: fetch stalls with PC held while the queue is full; head holds while out_ready is low.
module instruction_fetch_queue #(
  parameter int QUEUE_DEPTH = 4,
  parameter int MEM_WORDS   = 700,
  parameter int PC_OFFSET   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] process_base,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] read_address,
  input  logic [15:0] read_value,
  output logic [15:0] read_address2,
  input  logic [15:0] read_value2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_opcode,
  output logic [15:0] out_operand,
  output logic [15:0] out_pc,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LOAD_PC, FETCH, HALTED} state_t;

  state_t          state;
  state_t          state_next;
  logic [15:0]     base;
  logic [15:0]     pc;
  logic            fault_q;
  logic [15:0]     q_opcode  [QUEUE_DEPTH];
  logic [15:0]     q_operand [QUEUE_DEPTH];
  logic [15:0]     q_pc      [QUEUE_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [16:0]     fetch_end;
  logic            range_fault;
  logic            end_marker;
  logic            flush;
  logic            push;
  logic            pop;
  logic            load_pc;
  logic            set_fault;
  logic            take_redirect;

  // 17-bit sum so that a wrap past 0xFFFF is caught as out of range too.
  assign fetch_end   = {1'b0, base} + {1'b0, pc} + 17'd1;
  assign range_fault = (fetch_end >= 17'(MEM_WORDS));
  assign end_marker  = (read_value[15:12] == 4'hF);

  // Next state and per-cycle control; start beats redirect, redirect beats push/pop.
  always_comb begin
    state_next    = state;
    flush         = 1'b0;
    push          = 1'b0;
    load_pc       = 1'b0;
    set_fault     = 1'b0;
    take_redirect = 1'b0;
    if (start) begin
      state_next = LOAD_PC;
      flush      = 1'b1;
    end else if (redirect_valid && (state == FETCH || state == HALTED)) begin
      state_next    = FETCH;
      flush         = 1'b1;
      take_redirect = 1'b1;
    end else begin
      case (state)
        LOAD_PC: begin
          load_pc    = 1'b1;
          state_next = FETCH;
        end
        FETCH: begin
          if (range_fault) begin
            set_fault  = 1'b1;
            state_next = HALTED;
          end else if (end_marker) begin
            state_next = HALTED;
          end else if (count < CW'(QUEUE_DEPTH)) begin
            // Registered count: a pop this cycle does not free a slot until next cycle.
            push = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pop = (count != '0) && out_ready && !flush;

  // Memory addresses depend only on registered state, never on inputs.
  always_comb begin
    read_address  = 16'd0;
    read_address2 = 16'd0;
    case (state)
      LOAD_PC: read_address = base + 16'(PC_OFFSET);
      FETCH: begin
        read_address  = base + pc;
        read_address2 = base + pc + 16'd1;
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Base, PC, sticky fault and queue pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base    <= 16'd0;
      pc      <= 16'd0;
      fault_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (start) begin
        base    <= process_base;
        fault_q <= 1'b0;
      end
      if (set_fault) fault_q <= 1'b1;
      if (load_pc)            pc <= read_value;
      else if (take_redirect) pc <= redirect_pc;
      else if (push)          pc <= pc + 16'd2;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Queue storage; contents are only meaningful under count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_opcode[wr_ptr]  <= read_value;
      q_operand[wr_ptr] <= read_value2;
      q_pc[wr_ptr]      <= pc;
    end
  end

  assign out_valid   = (count != '0);
  assign out_opcode  = out_valid ? q_opcode[rd_ptr]  : 16'd0;
  assign out_operand = out_valid ? q_operand[rd_ptr] : 16'd0;
  assign out_pc      = out_valid ? q_pc[rd_ptr]      : 16'd0;
  assign busy        = (state == LOAD_PC) || (state == FETCH);
  assign halted      = (state == HALTED);
  assign fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: blockram model, directed scenarios and randomized images.
// Latency: expectations are cycle-exact for boot/redirect, scoreboard-ordered for random runs.
// Backpressure: out_ready is held low or randomized to exercise stall and head hold.
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] process_base;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] read_address;
  logic [15:0] read_value;
  logic [15:0] read_address2;
  logic [15:0] read_value2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_opcode;
  logic [15:0] out_operand;
  logic [15:0] out_pc;
  logic        busy;
  logic        halted;
  logic        fault;

  typedef struct {
    logic [15:0] op;
    logic [15:0] opd;
    logic [15:0] pc;
  } ent_t;

  logic [15:0] mem [0:699];
  ent_t        exp_q[$];
  logic        exp_fault;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [15:0] boot_op  [8] = '{16'h1210, 16'h2a05, 16'h3107, 16'h4402,
                                16'h5a0c, 16'h1c01, 16'h6e03, 16'h1800};
  logic [15:0] boot_opd [8] = '{16'h2613, 16'h0011, 16'h0100, 16'h00ff,
                                16'h1234, 16'h0002, 16'h0abc, 16'h0007};

  instruction_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .start(start), .process_base(process_base),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .read_address(read_address), .read_value(read_value),
    .read_address2(read_address2), .read_value2(read_value2),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_operand(out_operand), .out_pc(out_pc), .busy(busy),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Asynchronous-read blockram; out-of-range addresses return zero.
  always_comb begin
    read_value  = 16'd0;
    read_value2 = 16'd0;
    if (read_address  < 16'd700) read_value  = mem[int'(read_address)];
    if (read_address2 < 16'd700) read_value2 = mem[int'(read_address2)];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b);
    process_base = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Walks the process image by the fetch rules to list the instructions decode should see.
  task automatic model_walk(input int b, input int p0);
    int   p;
    ent_t e;
    p = p0;
    exp_q.delete();
    exp_fault = 1'b0;
    for (int guard = 0; guard < 400; guard++) begin
      if (b + p + 1 >= 700) begin
        exp_fault = 1'b1;
        break;
      end
      if (mem[b+p][15:12] == 4'hF) break;
      e.op  = mem[b+p];
      e.opd = mem[b+p+1];
      e.pc  = 16'(p);
      exp_q.push_back(e);
      p = (p + 2) & 16'hFFFF;
    end
  endtask

  // Drains the queue until halted and empty, comparing each accepted head with the model list.
  task automatic run_and_check(input string name, input bit rand_ready);
    int          idx;
    bit          hold_vld;
    bit          done;
    logic [47:0] held;
    logic [47:0] head;
    idx = 0; hold_vld = 1'b0; done = 1'b0; held = '0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      head = {out_opcode, out_operand, out_pc};
      if (out_valid) begin
        if (hold_vld) begin
          n_checks++;
          if (head !== held) begin
            n_fail++;
            $display("FAIL %s_hold: head %h, required %h", name, head, held);
          end
        end
        if (out_ready) begin
          n_checks++;
          if (idx >= exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_extra: unexpected entry %h beyond %0d expected", name, head, exp_q.size());
          end else if (head !== {exp_q[idx].op, exp_q[idx].opd, exp_q[idx].pc}) begin
            n_fail++;
            $display("FAIL %s_entry%0d: got %h, required %h", name, idx, head,
                     {exp_q[idx].op, exp_q[idx].opd, exp_q[idx].pc});
          end
          idx++;
          hold_vld = 1'b0;
        end else begin
          held = head;
          hold_vld = 1'b1;
        end
      end
      if (halted && !out_valid) done = 1'b1;
      else step();
    end
    out_ready = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL %s_timeout: halted=%b out_valid=%b, required halt and empty", name, halted, out_valid); end
    n_checks++;
    if (idx !== exp_q.size()) begin n_fail++; $display("FAIL %s_count: got %0d entries, required %0d", name, idx, exp_q.size()); end
    n_checks++;
    if (fault !== exp_fault) begin n_fail++; $display("FAIL %s_fault: got %b, required %b", name, fault, exp_fault); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; process_base = 16'h1234;
    redirect_valid = 1'b1; redirect_pc = 16'h0020; out_ready = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({out_valid, busy, halted, fault} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b, required 0000", {out_valid, busy, halted, fault}); end
    n_checks++;
    if ({read_address, read_address2} !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h, required 0", {read_address, read_address2}); end
    n_checks++;
    if ({out_opcode, out_operand, out_pc} !== 48'd0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", {out_opcode, out_operand, out_pc}); end
    rst_n = 1'b1; start = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    step();
    n_checks++;
    if ({busy, halted, read_address} !== 18'd0) begin n_fail++; $display("FAIL reset_idle: busy/halted/addr %h, required 0", {busy, halted, read_address}); end
  endtask

  task automatic test_boot();
    out_ready = 1'b1;
    do_start(16'd0);
    n_checks++;
    if ({busy, read_address, read_address2} !== {1'b1, 16'd4, 16'd0}) begin n_fail++; $display("FAIL boot_load_pc: got %h, required %h", {busy, read_address, read_address2}, {1'b1, 16'd4, 16'd0}); end
    step();
    n_checks++;
    if ({out_valid, read_address, read_address2} !== {1'b0, 16'd50, 16'd51}) begin n_fail++; $display("FAIL boot_fetch_addr: got %h, required %h", {out_valid, read_address, read_address2}, {1'b0, 16'd50, 16'd51}); end
    step();
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL boot_latency: out_valid %b 3 cycles after start, required 1", out_valid); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({out_valid, out_opcode, out_operand, out_pc} !== {1'b1, boot_op[k], boot_opd[k], 16'(50 + 2*k)}) begin
        n_fail++;
        $display("FAIL boot_entry%0d: got %h, required %h", k, {out_valid, out_opcode, out_operand, out_pc},
                 {1'b1, boot_op[k], boot_opd[k], 16'(50 + 2*k)});
      end
      step();
    end
    n_checks++;
    if ({halted, fault, out_valid, busy} !== 4'b1000) begin n_fail++; $display("FAIL boot_halt: halted/fault/valid/busy %b, required 1000", {halted, fault, out_valid, busy}); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    do_start(16'd0);
    repeat (8) step();
    n_checks++;
    if ({out_valid, out_pc, out_opcode, read_address} !== {1'b1, 16'd50, 16'h1210, 16'd58}) begin
      n_fail++;
      $display("FAIL bp_stall: valid/pc/op/addr %h, required %h", {out_valid, out_pc, out_opcode, read_address}, {1'b1, 16'd50, 16'h1210, 16'd58});
    end
    repeat (3) step();
    n_checks++;
    if ({out_pc, out_operand, read_address} !== {16'd50, 16'h2613, 16'd58}) begin n_fail++; $display("FAIL bp_hold: pc/operand/addr %h, required %h", {out_pc, out_operand, read_address}, {16'd50, 16'h2613, 16'd58}); end
    model_walk(0, 50);
    run_and_check("bp_drain", 1'b0);
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    do_start(16'd0);
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 16'd60; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if ({out_valid, busy, read_address} !== {1'b0, 1'b1, 16'd60}) begin n_fail++; $display("FAIL redir_flush: valid/busy/addr %h, required %h", {out_valid, busy, read_address}, {1'b0, 1'b1, 16'd60}); end
    step();
    n_checks++;
    if ({out_valid, out_pc, out_opcode, out_operand} !== {1'b1, 16'd60, 16'h1c01, 16'h0002}) begin
      n_fail++;
      $display("FAIL redir_head: got %h, required %h", {out_valid, out_pc, out_opcode, out_operand}, {1'b1, 16'd60, 16'h1c01, 16'h0002});
    end
    model_walk(0, 60);
    run_and_check("redir_drain", 1'b1);
  endtask

  task automatic test_fault();
    bit seen;
    mem[694] = 16'd50;
    out_ready = 1'b1;
    do_start(16'd690);
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fault_valid: out_valid %b at cycle %0d, required 0", out_valid, cyc); end
      if (halted) seen = 1'b1;
      else step();
    end
    n_checks++;
    if ({seen, halted, fault} !== 3'b111) begin n_fail++; $display("FAIL fault_set: seen/halted/fault %b, required 111", {seen, halted, fault}); end
    do_start(16'd200);
    n_checks++;
    if ({fault, busy} !== 2'b01) begin n_fail++; $display("FAIL fault_clear: fault/busy %b, required 01", {fault, busy}); end
  endtask

  task automatic test_random();
    int b;
    int p;
    int n;
    for (int it = 0; it < 4; it++) begin
      b = $urandom_range(100, 400);
      p = $urandom_range(6, 30);
      n = $urandom_range(2, 12);
      mem[b+4] = 16'(p);
      for (int i = 0; i < n; i++) begin
        mem[b+p+2*i]   = 16'($urandom) & 16'hEFFF;
        mem[b+p+2*i+1] = 16'($urandom);
      end
      mem[b+p+2*n] = 16'hF000 | (16'($urandom) & 16'h0FFF);
      model_walk(b, p);
      do_start(16'(b));
      run_and_check("rand_marker", 1'b1);
    end
    b = $urandom_range(640, 660);
    p = $urandom_range(6, 20);
    mem[b+4] = 16'(p);
    for (int a = b + p; a < 700; a++) mem[a] = 16'($urandom) & 16'hEFFF;
    model_walk(b, p);
    do_start(16'(b));
    run_and_check("rand_range", 1'b1);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    do_start(16'd0);
    repeat (4) step();
    n_checks++;
    if ({out_valid, read_address} !== {1'b1, 16'd56}) begin n_fail++; $display("FAIL midrst_pre: valid/addr %h, required %h", {out_valid, read_address}, {1'b1, 16'd56}); end
    rst_n = 1'b0;
    step();
    n_checks++;
    if ({out_valid, busy, halted, read_address} !== 19'd0) begin n_fail++; $display("FAIL midrst_clear: got %h, required 0", {out_valid, busy, halted, read_address}); end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({out_valid, busy, halted} !== 3'b000) begin n_fail++; $display("FAIL midrst_idle: valid/busy/halted %b, required 000", {out_valid, busy, halted}); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 700; a++) mem[a] = 16'd0;
    mem[4] = 16'd50;
    for (int k = 0; k < 8; k++) begin
      mem[50 + 2*k]     = boot_op[k];
      mem[50 + 2*k + 1] = boot_opd[k];
    end
    mem[66] = 16'hfb00;
    rst_n = 1'b0; start = 1'b0; process_base = 16'd0;
    redirect_valid = 1'b0; redirect_pc = 16'd0; out_ready = 1'b0;
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect();
    test_fault();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
